matrix_inverse_check: RTL
=========================

# matrix_inverse_check

Sequential 5x5 matrix multiplier and identity checker for the matrix-inverse datapath. It accepts an original matrix A and a candidate inverse B as a serial word stream and computes C = A×B with a single multiply-accumulate unit. It then streams C back out and flags whether C is exactly the identity matrix. It sits downstream of the inverse engine and closes the loop on its results: inversion produces B, and this block multiplies it back.

## Interface
- N, 5, matrix dimension (rows = columns)
- W, 16, element width in bits; all arithmetic is unsigned modulo 2^W
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  input  1  in_data holds a valid element
- in_ready  output  1  block accepts an element this cycle
- in_data  input  W  element; order is A row-major (A[0][0]..A[N-1][N-1]), then B row-major
- out_valid  output  1  out_data holds a valid C element
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  W  C element, row-major
- out_last  output  1  high with out_valid on C[N-1][N-1]
- is_identity  output  1  C == I; meaningful only while out_valid is high

## Operation
- States:
  - LOAD: in_ready=1; each in_valid&in_ready handshake stores in_data at load index 0..2N²-1. Indices 0..N²-1 go to A, N²..2N²-1 go to B.
  - LOAD → CALC on the handshake of index 2N²-1.
  - CALC: one MAC per cycle over nested counters i (row), j (col), k (inner), with k innermost.
    - At k=0: acc ← A[i][k]*B[k][j].
    - At other k: acc ← acc + A[i][k]*B[k][j].
    - At k=N-1: C[i][j] ← final sum.
    - Identity tracking: the flag idf starts at 1 on entry to CALC and is cleared if C[i][j] ≠ (i==j ? 1 : 0).
  - CALC → EMIT after the (i,j,k)=(N-1,N-1,N-1) cycle.
  - EMIT: out_valid=1, out_data=C[out_idx], out_last=(out_idx==N²-1), is_identity=idf.
    - out_idx advances on out_valid&out_ready.
    - The handshake on out_last returns the state to LOAD with all indices cleared.
- Arithmetic:
  - The product is the full 2W-bit value, truncated to W bits.
  - The accumulator is W bits with wrap-around; there is no saturation and no overflow flag.
- in_ready=0 outside LOAD; in_valid is ignored there. out_valid=0 outside EMIT.
- No A or B values are consumed from the stream while in CALC or EMIT; the producer must hold its data.

## Timing
- Reset values:
  - in_ready=1 (state LOAD).
  - out_valid=0, out_last=0, out_data=0, is_identity=0.
  - All counters 0, idf=1.
  - A, B and C storage are not reset.
- Input throughput: one element per cycle. 2N²=50 cycles minimum to load.
- CALC latency: exactly N³=125 cycles. out_valid rises at the clock edge 125 cycles after the edge that accepted the last B element.
- Output:
  - One element per cycle while out_ready=1.
  - While out_ready=0, out_data, out_last and is_identity hold stable.
  - out_valid never drops until its handshake.
- Turnaround: in_ready rises at the edge after the out_last handshake. Minimum frame period is 50+125+25=200 cycles.
- Reset asserted mid-operation (any state): outputs take their reset values immediately (asynchronous). State returns to LOAD; any partial frame is discarded and the next accepted word is A[0][0].
- Reset released: first handshake can occur in the first cycle after deassertion is sampled.

## Test plan
- A=I, B=I, out_ready=1 → 25 outputs equal to I, is_identity=1 throughout EMIT, out_last on the 25th output, out_valid exactly 125 cycles after the last input.
- A=I, B[r][c]=16·r+c → C=B element-for-element (0x00..0x44 pattern), is_identity=0.
- A = upper-triangular all-ones, B = I with superdiagonal 0xFFFF → C=I modulo 2^16, is_identity=1.
- A=2·I, B=0x8000·I → every diagonal C = 0x0000 (wrap), off-diagonal 0, is_identity=0.
- Backpressure: random in_valid gaps and out_ready toggling ~50% → same C values as with no stalls; out_data stable while stalled; in_ready=0 during CALC/EMIT.
- Reset pulsed at CALC cycle 60 → outputs zero immediately, in_ready=1 after release; a fresh I×I frame then yields is_identity=1.

Source files
------------

// File: rtl/matrix_inverse_check.sv
// Multiplies a candidate inverse B by the original matrix A with one MAC unit,
// streams C = A*B out row-major and flags whether C is exactly the identity.
module matrix_inverse_check #(
    parameter int N = 5,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         is_identity
);

    localparam int IDXW = $clog2(N * N);
    localparam int LDW  = $clog2(2 * N * N);
    localparam int CW   = $clog2(N);

    localparam logic [LDW-1:0]  LD_SPLIT = LDW'(N * N);
    localparam logic [LDW-1:0]  LD_LAST  = LDW'(2 * N * N - 1);
    localparam logic [IDXW-1:0] OUT_LAST = IDXW'(N * N - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LDW-1:0]  ld_idx_q, ld_idx_d;
    logic [CW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            idf_q, idf_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;

    logic [W-1:0] a_mem [N*N];
    logic [W-1:0] b_mem [N*N];
    logic [W-1:0] c_mem [N*N];

    logic            a_we, b_we, c_we;
    logic [IDXW-1:0] a_addr, b_addr, c_addr, bl_addr;
    logic [2*W-1:0]  prod_full;
    logic [W-1:0]    mac_sum;
    logic [W-1:0]    c_expect;

    assign a_addr    = IDXW'(i_q * N + k_q);
    assign b_addr    = IDXW'(k_q * N + j_q);
    assign c_addr    = IDXW'(i_q * N + j_q);
    assign bl_addr   = IDXW'(ld_idx_q - LD_SPLIT);
    assign prod_full = (2*W)'(a_mem[a_addr]) * (2*W)'(b_mem[b_addr]);
    // Product keeps only its low W bits; accumulation wraps modulo 2^W.
    assign mac_sum   = (k_q == '0) ? prod_full[W-1:0] : acc_q + prod_full[W-1:0];
    assign c_expect  = (i_q == j_q) ? W'(1) : '0;

    always_comb begin
        state_d   = state_q;
        ld_idx_d  = ld_idx_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        idf_d     = idf_q;
        out_idx_d = out_idx_q;
        a_we      = 1'b0;
        b_we      = 1'b0;
        c_we      = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    a_we = (ld_idx_q < LD_SPLIT);
                    b_we = !(ld_idx_q < LD_SPLIT);
                    if (ld_idx_q == LD_LAST) begin
                        ld_idx_d = '0;
                        idf_d    = 1'b1;
                        state_d  = CALC;
                    end else begin
                        ld_idx_d = ld_idx_q + 1'b1;
                    end
                end
            end
            CALC: begin
                acc_d = mac_sum;
                if (k_q == CNT_LAST) begin
                    c_we = 1'b1;
                    k_d  = '0;
                    if (mac_sum != c_expect) idf_d = 1'b0;
                    if (j_q == CNT_LAST) begin
                        j_d = '0;
                        if (i_q == CNT_LAST) begin
                            i_d     = '0;
                            state_d = EMIT;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_idx_q == OUT_LAST) begin
                        out_idx_d = '0;
                        state_d   = LOAD;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD;
            ld_idx_q  <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            idf_q     <= 1'b1;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_idx_q  <= ld_idx_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            idf_q     <= idf_d;
            out_idx_q <= out_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (a_we) a_mem[ld_idx_q[IDXW-1:0]] <= in_data;
        if (b_we) b_mem[bl_addr] <= in_data;
        if (c_we) c_mem[c_addr] <= mac_sum;
    end

    // Outputs decode straight from state so reset clears them without a clock.
    always_comb begin
        in_ready    = (state_q == LOAD);
        out_valid   = (state_q == EMIT);
        out_data    = (state_q == EMIT) ? c_mem[out_idx_q] : '0;
        out_last    = (state_q == EMIT) && (out_idx_q == OUT_LAST);
        is_identity = (state_q == EMIT) && idf_q;
    end

endmodule
